// File: rtl/sram_fifo_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sram_fifo_ctrl_if
// Description : Push stream, pop stream, occupancy and SRAM port bundle for
//               the SRAM-backed FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_fifo_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 14
);
    // upstream push stream
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    // downstream pop stream
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    // total words held
    logic [AW:0]   occ;
    // SRAM write port
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    // SRAM read port (registered read data)
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    // controller side
    modport slave (
        input  in_valid, in_data, out_ready, rd_data,
        output in_ready, out_valid, out_data, occ,
               wr_en, wr_addr, wr_data, rd_en, rd_addr
    );

    // environment side (stream source/sink and SRAM)
    modport master (
        output in_valid, in_data, out_ready, rd_data,
        input  in_ready, out_valid, out_data, occ,
               wr_en, wr_addr, wr_data, rd_en, rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sram_fifo_ctrl
// Description : Streaming FIFO built on a dual-port SRAM with one-cycle
//               registered read latency. A 3-entry output buffer hides the
//               read latency so the pop side runs one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 14,
    parameter int DEPTH = 16384
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    sram_fifo_ctrl_if.slave       bus
);

    localparam logic [AW:0] c_FULL     = (AW+1)'(DEPTH);
    localparam logic [2:0]  c_OB_SLOTS = 3'd3;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   sram_cnt_q, sram_cnt_d;
    logic          inflight_q;
    logic [DW-1:0] ob_q [3];
    logic [DW-1:0] ob_d [3];
    logic [1:0]    ob_cnt_q, ob_cnt_d;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_rd;
    logic [2:0]    w_pending;
    logic [1:0]    w_cap_idx;

    // Push side: refuse only while the SRAM itself is full; the output
    // buffer never lends capacity to the input in the same cycle.
    assign w_in_ready  = (sram_cnt_q != c_FULL);
    assign w_out_valid = (ob_cnt_q != 2'd0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Issue a read only when a buffer slot is reserved for its data, counting
    // the read already in flight, so capture never overflows the buffer.
    assign w_pending   = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
    assign w_rd        = (sram_cnt_q != '0) && (w_pending < c_OB_SLOTS);

    assign bus.in_ready  = w_in_ready;
    assign bus.wr_en     = w_push;
    assign bus.wr_addr   = wptr_q;
    assign bus.wr_data   = bus.in_data;
    assign bus.rd_en     = w_rd;
    assign bus.rd_addr   = rptr_q;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = ob_q[0];
    assign bus.occ       = sram_cnt_q + {{AW{1'b0}}, inflight_q}
                                      + {{(AW-1){1'b0}}, ob_cnt_q};

    // Next-state for pointers, SRAM count and the shifting output buffer.
    always_comb begin
        wptr_d     = wptr_q + {{(AW-1){1'b0}}, w_push};
        rptr_d     = rptr_q + {{(AW-1){1'b0}}, w_rd};
        sram_cnt_d = sram_cnt_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_rd};
        ob_cnt_d   = ob_cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
        w_cap_idx  = ob_cnt_q - {1'b0, w_pop};
        ob_d       = ob_q;
        // Head always lives in entry 0 so out_data comes straight off a flop.
        if (w_pop) begin
            ob_d[0] = ob_q[1];
            ob_d[1] = ob_q[2];
            ob_d[2] = '0;
        end
        // Returning read data lands just behind the surviving entries.
        if (inflight_q) begin
            if (w_cap_idx == 2'd0) begin
                ob_d[0] = bus.rd_data;
            end else if (w_cap_idx == 2'd1) begin
                ob_d[1] = bus.rd_data;
            end else begin
                ob_d[2] = bus.rd_data;
            end
        end
    end

    // State registers; reset discards everything so stale SRAM data is lost.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            sram_cnt_q <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                ob_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            sram_cnt_q <= sram_cnt_d;
            inflight_q <= w_rd;
            ob_cnt_q   <= ob_cnt_d;
            ob_q       <= ob_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_fifo_ctrl
// Description : Self-checking bench for sram_fifo_ctrl with an SRAM model,
//               a vector table and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int DEPTH = 16384;
    localparam int CAP   = DEPTH + 3;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    sram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    sram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // SRAM with registered read data
    logic [DW-1:0] sram [DEPTH];
    always @(posedge sys_clk) begin
        if (bus.wr_en) sram[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_en) bus.rd_data <= sram[bus.rd_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: words in FIFO order with their push cycle
    logic [DW-1:0] q_data [$];
    int            q_time [$];
    int            front_since;
    int            n_push;
    int            n_rd;
    logic          last_push, last_pop;
    logic [DW-1:0] last_pop_data;
    logic          prev_hold;
    logic [DW-1:0] prev_data;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_rdy;
        logic          e_wr;
        logic [AW-1:0] e_waddr;
        logic          e_rd;
        logic [AW-1:0] e_raddr;
        logic          e_ov;
        logic [DW-1:0] e_odata;
        logic [AW:0]   e_occ;
    } vec_t;
    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_time.delete();
        front_since = 0;
        n_push      = 0;
        n_rd        = 0;
        prev_hold   = 1'b0;
        prev_data   = '0;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    // called just after a rising edge
    task automatic do_reset(input int ncyc);
        drive_idle();
        sys_rst_n = 1'b0;
        repeat (ncyc) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    // One model-checked cycle: drive, sample at the falling edge, update model.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
        logic push, pop;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(negedge sys_clk);
        check("occ", bus.occ, q_data.size());
        if (q_data.size() < DEPTH)    check("in_ready", bus.in_ready, 1);
        else if (q_data.size() == CAP) check("in_ready_full", bus.in_ready, 0);
        push = iv & bus.in_ready;
        check("wr_en", bus.wr_en, push);
        if (push) begin
            check("wr_addr", bus.wr_addr, n_push % DEPTH);
            check("wr_data", bus.wr_data, d);
        end
        if (q_data.size() == 0) begin
            check("empty_rd_en", bus.rd_en, 0);
            check("empty_out_valid", bus.out_valid, 0);
        end else if (q_time[0] <= cyc - 3 && front_since <= cyc - 2) begin
            check("out_valid_live", bus.out_valid, 1);
        end
        if (bus.rd_en) begin
            check("rd_addr", bus.rd_addr, n_rd % DEPTH);
            n_rd++;
        end
        if (prev_hold) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, prev_data);
        end
        prev_hold = bus.out_valid & ~ordy;
        prev_data = bus.out_data;
        pop = bus.out_valid & ordy;
        last_pop_data = bus.out_data;
        if (pop) begin
            if (q_data.size() == 0) begin
                check("pop_on_empty", bus.out_valid, 0);
            end else begin
                check("out_data", bus.out_data, q_data[0]);
                void'(q_data.pop_front());
                void'(q_time.pop_front());
                front_since = cyc + 1;
            end
        end
        if (push) begin
            if (q_data.size() == 0) front_since = cyc;
            q_data.push_back(d);
            q_time.push_back(cyc);
            n_push++;
        end
        last_push = push;
        last_pop  = pop;
        cyc++;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted, popped, sent, budget;

        // iv, d, ordy | rdy, wr, waddr, rd, raddr, ov, odata, occ
        vt[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 14'd0, 1'b0, 14'd0, 1'b0, 16'h0000, 15'd0};
        vt[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 14'd0, 1'b1, 14'd0, 1'b0, 16'h0000, 15'd1};
        vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b0, 16'h0000, 15'd1};
        vt[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b1, 16'hA5A5, 15'd1};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b1, 16'hA5A5, 15'd1};
        vt[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b0, 16'h0000, 15'd0};
        vt[6]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 14'd1, 1'b0, 14'd0, 1'b0, 16'h0000, 15'd0};
        vt[7]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 14'd2, 1'b1, 14'd1, 1'b0, 16'h0000, 15'd1};
        vt[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 14'd0, 1'b1, 14'd2, 1'b0, 16'h0000, 15'd2};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b1, 16'h1111, 15'd2};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b1, 16'h2222, 15'd1};
        vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b0, 16'h0000, 15'd0};

        // ---- reset: low for 3 cycles ----
        drive_idle();
        sys_rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_occ", bus.occ, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        @(posedge sys_clk);
        #1;

        // ---- single word / two word latency table ----
        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = vt[i].iv;
            bus.in_data   = vt[i].d;
            bus.out_ready = vt[i].ordy;
            @(negedge sys_clk);
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, vt[i].e_rdy);
            check($sformatf("vec%0d_wr_en", i), bus.wr_en, vt[i].e_wr);
            if (vt[i].e_wr) begin
                check($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vt[i].e_waddr);
                check($sformatf("vec%0d_wr_data", i), bus.wr_data, vt[i].d);
            end
            check($sformatf("vec%0d_rd_en", i), bus.rd_en, vt[i].e_rd);
            if (vt[i].e_rd) check($sformatf("vec%0d_rd_addr", i), bus.rd_addr, vt[i].e_raddr);
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, vt[i].e_ov);
            if (vt[i].e_ov) check($sformatf("vec%0d_out_data", i), bus.out_data, vt[i].e_odata);
            check($sformatf("vec%0d_occ", i), bus.occ, vt[i].e_occ);
            @(posedge sys_clk);
            #1;
        end

        // ---- streaming 0..99 with out_ready high ----
        do_reset(2);
        for (int k = 0; k < 110; k++) begin
            step(k < 100, 16'(k), 1'b1);
            check("stream_pop_slot", last_pop, (k >= 3 && k < 103));
            if (k >= 3 && k < 103) check("stream_data", last_pop_data, k - 3);
        end

        // ---- fill to capacity, drain, push 10 more across the wrap ----
        do_reset(2);
        accepted = 0;
        for (int k = 0; k < CAP + 20; k++) begin
            step(1'b1, 16'(k ^ 32'h5A5A), 1'b0);
            if (last_push) accepted++;
        end
        check("fill_accepted", accepted, CAP);
        @(negedge sys_clk);
        check("fill_occ", bus.occ, CAP);
        check("fill_in_ready", bus.in_ready, 0);
        check("fill_out_valid", bus.out_valid, 1);
        @(posedge sys_clk);
        #1;
        popped = 0;
        budget = CAP + 100;
        while (q_data.size() > 0 && budget > 0) begin
            step(1'b0, '0, 1'b1);
            if (last_pop) popped++;
            budget--;
        end
        check("drain_count", popped, CAP);
        for (int k = 0; k < 10; k++) step(1'b1, 16'(16'hC000 + k), 1'b1);
        budget = 50;
        while (q_data.size() > 0 && budget > 0) begin
            step(1'b0, '0, 1'b1);
            budget--;
        end
        check("wrap_drained", q_data.size(), 0);
        check("wrap_wr_ptr", n_push % DEPTH, (CAP + 10) % DEPTH);

        // ---- random backpressure, 5000 words ----
        do_reset(2);
        sent   = 0;
        popped = 0;
        budget = 40000;
        while (popped < 5000 && budget > 0) begin
            step((sent < 5000) && ($urandom_range(0, 1) == 1), 16'($urandom),
                 ($urandom_range(0, 1) == 1));
            if (last_push) sent++;
            if (last_pop) popped++;
            budget--;
        end
        check("random_popped", popped, 5000);
        check("random_empty", q_data.size(), 0);

        // ---- reset mid-stream ----
        do_reset(2);
        budget = 200;
        while (q_data.size() < 50 && budget > 0) begin
            step(1'b1, 16'($urandom), 1'b0);
            budget--;
        end
        check("mid_occ50", q_data.size(), 50);
        drive_idle();
        sys_rst_n = 1'b0;
        #1;
        check("mid_async_occ", bus.occ, 0);
        check("mid_async_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();
        @(negedge sys_clk);
        check("mid_wr_addr", bus.wr_addr, 0);
        check("mid_rd_addr", bus.rd_addr, 0);
        @(posedge sys_clk);
        #1;
        step(1'b1, 16'h1234, 1'b0);
        budget = 20;
        popped = 0;
        while (popped == 0 && budget > 0) begin
            step(1'b0, '0, 1'b1);
            if (last_pop) begin
                popped++;
                check("mid_first_out", last_pop_data, 16'h1234);
            end
            budget--;
        end
        check("mid_popped", popped, 1);
        step(1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
